// File: rtl/neighbour_context_gen.sv
// neighbour_context_gen
//   Builds the JPEG-LS causal neighbourhood for a raster-order pixel stream.
//   For every accepted sample x it outputs a (left), b (above), c (above-left)
//   and d (above-right), using a one-row line buffer. Edge rules are applied
//   at row 0 and at both row ends. Outputs are registered with one cycle of
//   latency, and EOL/start_enc drive the mode-determination stage.
//
// Optional build macro: NEIGH_BACKPRESSURE_EN
//   Adds the out_ready input. Outputs stall while start_enc=1 and out_ready=0.
//   When the macro is absent, pix_ready is constant 1.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous reset, active low
//   sof         start of frame, qualified by pix_valid
//   pix_in      input sample
//   pix_valid   pix_in valid
//   pix_ready   block accepts pix_in this cycle
//   out_ready   (NEIGH_BACKPRESSURE_EN only) downstream accepts outputs
//   a,b,c,d,x   registered neighbourhood and current sample
//   EOL         x is the last sample of its row
//   start_enc   a/b/c/d/x/EOL valid this cycle
//   frame_done  pulse with the final sample of the frame
module neighbour_context_gen #(
  parameter int pixel_length = 8,
  parameter int image_width  = 64,
  parameter int image_height = 64,
  parameter int col_bits     = 6,
  parameter int row_bits     = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sof,
  input  logic [pixel_length-1:0] pix_in,
  input  logic                    pix_valid,
`ifdef NEIGH_BACKPRESSURE_EN
  input  logic                    out_ready,
`endif
  output logic                    pix_ready,
  output logic [pixel_length-1:0] a,
  output logic [pixel_length-1:0] b,
  output logic [pixel_length-1:0] c,
  output logic [pixel_length-1:0] d,
  output logic [pixel_length-1:0] x,
  output logic                    EOL,
  output logic                    start_enc,
  output logic                    frame_done
);

  localparam logic [col_bits-1:0] LAST_COL = col_bits'(image_width - 1);
  localparam logic [row_bits-1:0] LAST_ROW = row_bits'(image_height - 1);

  typedef enum logic [1:0] {IDLE, FIRST_ROW, NEXT_ROWS} state_t;

  state_t                  state, state_nxt;
  logic [col_bits-1:0]     col;
  logic [row_bits-1:0]     row;
  logic [pixel_length-1:0] c_start;
  logic [pixel_length-1:0] linebuf [image_width];

  logic                    accept, stall, start_frame, take, in_first;
  logic                    last_col, last_row;
  logic [col_bits-1:0]     col_p0, col_inc_p0;
  logic [row_bits-1:0]     row_p0;
  logic [pixel_length-1:0] above_b_p0, above_d_p0;
  logic [pixel_length-1:0] a_p0, b_p0, c_p0, d_p0;

`ifdef NEIGH_BACKPRESSURE_EN
  // A held output blocks new input until downstream takes it.
  assign stall     = start_enc && !out_ready;
  assign pix_ready = out_ready || !start_enc;
`else
  assign stall     = 1'b0;
  assign pix_ready = 1'b1;
`endif

  assign accept = pix_valid && pix_ready;

  // Stage p0: neighbourhood selection from line buffer and previous outputs
  always_comb begin
    start_frame = accept && sof;
    // Pixels that arrive in IDLE without sof are swallowed.
    take        = accept && (start_frame || (state != IDLE));
    col_p0      = start_frame ? '0 : col;
    row_p0      = start_frame ? '0 : row;
    in_first    = start_frame || (state == FIRST_ROW);
    last_col    = (col_p0 == LAST_COL);
    last_row    = (row_p0 == LAST_ROW);
    col_inc_p0  = col_p0 + col_bits'(1);
    above_b_p0  = linebuf[col_p0];
    // Beyond the right edge, d replicates b. The wrapped index is never used.
    above_d_p0  = last_col ? above_b_p0 : linebuf[col_inc_p0];
    a_p0 = '0;
    b_p0 = '0;
    c_p0 = '0;
    d_p0 = '0;
    if (in_first) begin
      a_p0 = (col_p0 == '0) ? '0 : x;
    end else begin
      b_p0 = above_b_p0;
      d_p0 = above_d_p0;
      if (col_p0 == '0) begin
        a_p0 = above_b_p0;
        c_p0 = c_start;
      end else begin
        a_p0 = x;
        c_p0 = b;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (take) begin
      if (last_col && last_row) state_nxt = IDLE;
      else if (last_col)        state_nxt = NEXT_ROWS;
      else if (in_first)        state_nxt = FIRST_ROW;
      else                      state_nxt = NEXT_ROWS;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Stage p1: registered outputs and counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a          <= '0;
      b          <= '0;
      c          <= '0;
      d          <= '0;
      x          <= '0;
      EOL        <= 1'b0;
      start_enc  <= 1'b0;
      frame_done <= 1'b0;
      col        <= '0;
      row        <= '0;
      c_start    <= '0;
    end else if (take) begin
      a          <= a_p0;
      b          <= b_p0;
      c          <= c_p0;
      d          <= d_p0;
      x          <= pix_in;
      EOL        <= last_col;
      start_enc  <= 1'b1;
      frame_done <= last_col && last_row;
      col        <= last_col ? '0 : col_inc_p0;
      if (last_col) row <= last_row ? '0 : row_p0 + row_bits'(1);
      else          row <= row_p0;
      // c for the next row's column 0 is this row's column-0 b.
      if (col_p0 == '0) c_start <= b_p0;
    end else if (!stall) begin
      start_enc  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

  // Write-after-read: the same-cycle read above still sees the previous row.
  always_ff @(posedge clk) begin
    if (take) linebuf[col_p0] <= pix_in;
  end

endmodule

// File: tb/tb_neighbour_context_gen.sv
module tb_neighbour_context_gen;
  localparam int W = 4;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       reset, sof, pix_valid, pix_ready;
  logic [7:0] pix_in, a, b, c, d, x;
  logic       EOL, start_enc, frame_done;
  logic       out_ready_eff;
  bit         bp_rand = 0;

`ifdef NEIGH_BACKPRESSURE_EN
  logic out_ready = 1'b1;
  assign out_ready_eff = out_ready;
  initial forever begin
    @(posedge clk); #2;
    out_ready = bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end
`else
  assign out_ready_eff = 1'b1;
`endif

  neighbour_context_gen #(.pixel_length(8), .image_width(W), .image_height(H),
                          .col_bits(2), .row_bits(2)) dut (
    .clk(clk), .reset(reset), .sof(sof), .pix_in(pix_in), .pix_valid(pix_valid),
`ifdef NEIGH_BACKPRESSURE_EN
    .out_ready(out_ready),
`endif
    .pix_ready(pix_ready), .a(a), .b(b), .c(c), .d(d), .x(x),
    .EOL(EOL), .start_enc(start_enc), .frame_done(frame_done));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a, b, c, d, x;
    logic       eol, fd;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int ea, eb, ec, ed, ex, input bit eeol, efd);
    exp_t e;
    e.a = 8'(ea); e.b = 8'(eb); e.c = 8'(ec); e.d = 8'(ed); e.x = 8'(ex);
    e.eol = eeol; e.fd = efd;
    return e;
  endfunction

  // Reference model: the frame is kept as a 2-D image and each neighbour is
  // read straight from image coordinates.
  logic [7:0] img [H][W];
  int         mr = 0, mc = 0;
  bit         in_frame = 0;
  logic [7:0] last_x;

  task automatic model_step(input logic [7:0] p, input logic s, output bit prod, output exp_t e);
    prod = 0;
    e = '0;
    if (s) begin in_frame = 1; mr = 0; mc = 0; end
    if (in_frame) begin
      img[mr][mc] = p;
      e.x = p;
      if (mr == 0) begin
        e.a = (mc == 0) ? 8'd0 : img[0][mc-1];
      end else begin
        e.b = img[mr-1][mc];
        e.d = (mc == W-1) ? e.b : img[mr-1][mc+1];
        e.a = (mc == 0) ? e.b : img[mr][mc-1];
        if (mc == 0) e.c = (mr >= 2) ? img[mr-2][0] : 8'd0;
        else         e.c = img[mr-1][mc-1];
      end
      e.eol = (mc == W-1);
      e.fd  = e.eol && (mr == H-1);
      prod  = 1;
      mc++;
      if (mc == W) begin
        mc = 0;
        mr++;
        if (mr == H) begin mr = 0; in_frame = 0; end
      end
    end
  endtask

  // Called at posedge+2; returns at posedge+2 after the accepting edge.
  task automatic send(input logic [7:0] p, input logic s, input bit use_exp, input exp_t ex);
    bit   acc;
    bit   prod;
    exp_t e;
    int   n = 0;
    pix_in = p; sof = s; pix_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = pix_ready;
      @(posedge clk); #2;
      n++;
      if (n > 1000) begin
        errors++;
        $display("FAIL send_timeout: got no acceptance expected acceptance within 1000 cycles");
        $fatal(1, "stalled");
      end
    end while (!acc);
    pix_valid = 1'b0; sof = 1'b0;
    model_step(p, s, prod, e);
    if (prod) begin
      q.push_back(use_exp ? ex : e);
      last_x = p;
    end
  endtask

  task automatic send_m(input logic [7:0] p, input logic s);
    send(p, s, 0, '0);
  endtask

  // Monitor: each new output presentation is compared once.
  bit seen = 0;
  initial forever begin
    @(negedge clk);
    if (!start_enc) seen = 0;
    else if (!seen) begin
      seen = 1;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got x=%0d expected no output", x);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("neigh", 64'({a, b, c, d, x, EOL, frame_done}), 64'(e));
      end
    end
    if (out_ready_eff) seen = 0;
  end

  int   dpix [12] = '{10, 20, 30, 40, 50, 60, 70, 80, 1, 2, 3, 4};
  exp_t dexp [12];

  initial begin
    dexp[0]  = mk(0, 0, 0, 0, 10, 0, 0);   dexp[1]  = mk(10, 0, 0, 0, 20, 0, 0);
    dexp[2]  = mk(20, 0, 0, 0, 30, 0, 0);  dexp[3]  = mk(30, 0, 0, 0, 40, 1, 0);
    dexp[4]  = mk(10, 10, 0, 20, 50, 0, 0); dexp[5] = mk(50, 20, 10, 30, 60, 0, 0);
    dexp[6]  = mk(60, 30, 20, 40, 70, 0, 0); dexp[7] = mk(70, 40, 30, 40, 80, 1, 0);
    dexp[8]  = mk(50, 50, 10, 60, 1, 0, 0);  dexp[9] = mk(1, 60, 50, 70, 2, 0, 0);
    dexp[10] = mk(2, 70, 60, 80, 3, 0, 0);   dexp[11] = mk(3, 80, 70, 80, 4, 1, 1);

    reset = 1'b0; sof = 1'b0; pix_valid = 1'b0; pix_in = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_outputs", 64'({a, b, c, d, x, EOL, start_enc, frame_done}), 64'd0);
    chk("pix_ready_reset", 64'(pix_ready), 64'd1);
    reset = 1'b1;
    @(posedge clk); #2;

    // Pixels without sof while idle are dropped.
    send_m(8'd99, 1'b0);
    @(negedge clk);
    chk("idle_drop_start_enc", 64'(start_enc), 64'd0);
    @(posedge clk); #2;
    send_m(8'd98, 1'b0);
    @(negedge clk);
    chk("idle_drop_start_enc2", 64'(start_enc), 64'd0);
    @(posedge clk); #2;

    // Directed frame with fixed expectations.
    for (int i = 0; i < 12; i++) send(8'(dpix[i]), i == 0, 1, dexp[i]);
    @(posedge clk); #2;
    chk("frame_returns_idle_drop", 64'(q.size()), 64'd0);
    send_m(8'd77, 1'b0);
    @(negedge clk);
    chk("after_frame_drop", 64'(start_enc), 64'd0);
    @(posedge clk); #2;

    // Mid-row stall of the input, then resume.
    send_m(8'd5, 1'b1);
    send_m(8'd6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      @(negedge clk);
      chk("gap_start_enc", 64'(start_enc), 64'd0);
      chk("gap_x_hold", 64'(x), 64'(last_x));
    end
    @(posedge clk); #2;
    for (int i = 2; i < 12; i++) send_m(8'(7 + i * 13), 1'b0);

    // Restart on the third pixel of row 1.
    for (int i = 0; i < 6; i++) send_m(8'(100 + i), i == 0);
    send(8'd200, 1'b1, 1, mk(0, 0, 0, 0, 200, 0, 0));
    send_m(8'd201, 1'b0);
    @(posedge clk); #2;

    // Asynchronous reset mid-row.
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", 64'({a, b, c, d, x, EOL, start_enc, frame_done}), 64'd0);
    q.delete();
    in_frame = 0; mr = 0; mc = 0;
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    send_m(8'd33, 1'b0);
    @(negedge clk);
    chk("post_reset_drop", 64'(start_enc), 64'd0);
    @(posedge clk); #2;

    // Randomized frames with gaps, stray pixels and occasional restarts.
    bp_rand = 1;
    for (int f = 0; f < 10; f++) begin
      if ($urandom_range(0, 2) == 0) send_m(8'($urandom), 1'b0);
      for (int k = 0; k < W * H; k++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
        send_m(8'($urandom), (k == 0) || ($urandom_range(0, 30) == 0));
      end
    end

    bp_rand = 0;
    for (int n = 0; n < 200 && q.size() != 0; n++) @(posedge clk);
    @(negedge clk);
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/neighbour_context_gen.md
Name: neighbour_context_gen

Overview:
- Sits directly upstream of the mode-determination stage in the JPEG-LS encoder.
- Takes a raster-order pixel stream and produces the causal neighbourhood a (left), b (above), c (above-left), d (above-right) together with the current sample x.
- Holds the previous image row in an internal line buffer and applies the JPEG-LS edge rules at the first row and at the row ends.
- Drives the EOL and start_enc signals that the mode-determination stage consumes.

Parameters:
- pixel_length, 8, sample bit width.
- image_width, 64, samples per row (>=2).
- image_height, 64, rows per frame (>=1).
- col_bits, 6, column counter width; must satisfy 2^col_bits >= image_width.
- row_bits, 6, row counter width; must satisfy 2^row_bits >= image_height.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous active-low reset; asserted when 0.
- sof  input  1  start-of-frame; qualifies the first pixel of a frame, sampled only with pix_valid.
- pix_in  input  pixel_length  raster-order input sample.
- pix_valid  input  1  pix_in is valid this cycle.
- pix_ready  output  1  block accepts pix_in this cycle.
- a, b, c, d, x  output  pixel_length  registered neighbourhood and current sample.
- EOL  output  1  the x being output is the last sample of its row.
- start_enc  output  1  a/b/c/d/x/EOL are valid this cycle.
- frame_done  output  1  one-cycle pulse together with the final sample of the frame.

Behaviour:
- Reset (reset=0, asynchronous):
  - a, b, c, d, x = 0; EOL, start_enc, frame_done = 0.
  - col and row = 0; c_start = 0; state = IDLE.
  - Line buffer contents are don't-care; the first-row rule masks them.
- Acceptance: a pixel is accepted when pix_valid && pix_ready. Latency is 1 cycle: outputs update on the clock edge that accepts the pixel.
- Idle cycles: on a cycle with no acceptance, start_enc and frame_done go to 0. a/b/c/d/x/EOL hold their values.
- States:
  - IDLE: waits for an accepted pixel with sof=1. Accepted pixels with sof=0 are dropped, and start_enc stays 0.
  - FIRST_ROW: row 0 of the frame.
  - NEXT_ROWS: rows 1 to image_height-1.
- sof during FIRST_ROW or NEXT_ROWS restarts the frame: col and row go to 0 and that pixel is processed as row 0, column 0 of a new frame.
- FIRST_ROW neighbourhood, for column col:
  - b = c = d = 0.
  - a = 0 when col=0, otherwise the previous x.
- NEXT_ROWS neighbourhood, for column col:
  - b = linebuf[col].
  - d = linebuf[col+1]; d = b when col = image_width-1.
  - col=0: a = b and c = c_start.
  - col>0: a = previous x and c = the previous cycle's b.
- c_start: at col=0, c_start captures the b being output (it is 0 in the first row).
- Line buffer write: every accepted pixel writes linebuf[col] = pix_in. The read of linebuf[col] in the same cycle returns the old value, i.e. the row above.
- Counters:
  - col increments per accepted pixel and wraps to 0 after image_width-1.
  - On that wrap EOL=1; row increments and the state moves FIRST_ROW -> NEXT_ROWS.
  - At the last pixel (row = image_height-1, col = image_width-1): frame_done=1, state -> IDLE.
- image_height=1: a frame is FIRST_ROW only; it goes FIRST_ROW -> IDLE directly.
- pix_ready is tied to 1, unless the optional feature is compiled in.
- No arithmetic is performed; all outputs are pure sample copies with no width change.

Optional Feature:
- Macro: NEIGH_BACKPRESSURE_EN.
- With the macro: adds input port out_ready (1 bit).
  - pix_ready = out_ready || !start_enc.
  - While start_enc=1 and out_ready=0, all outputs hold and no pixel is accepted. No pixel may be lost or duplicated.
- Without the macro: the out_ready port is absent and pix_ready is constant 1.

Test Plan:
Common setup: image_width=4, image_height=3; frame rows are 10,20,30,40 / 50,60,70,80 / 1,2,3,4.
1. Reset held low for 2 cycles, then released -> all outputs 0 and start_enc=0. Pixels with sof=0 are ignored: start_enc stays 0.
2. First row with sof on pixel 10:
   - Outputs (a,b,c,d,x) = (0,0,0,0,10), (10,0,0,0,20), (20,0,0,0,30), (30,0,0,0,40).
   - EOL=1 on the 4th output only.
3. Second row:
   - Outputs (10,10,0,20,50), (50,20,10,30,60), (60,30,20,40,70), (70,40,30,40,80).
   - EOL=1 on the last output.
4. Third row:
   - Outputs (50,50,10,60,1), (1,60,50,70,2), (2,70,60,80,3), (3,80,70,80,4).
   - frame_done=1 on the last output only; the state then returns to IDLE.
5. pix_valid deasserted for 3 cycles mid-row -> start_enc=0 and outputs hold. On resume, the neighbourhood continues correctly (a = last x).
6. sof reasserted on the 3rd pixel of row 1 -> that pixel outputs (0,0,0,0,x). Also: asynchronous reset mid-row clears all outputs immediately, without waiting for a clock edge.
